// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per RUN cycle, LSB digit first, with carry/overflow/zero/negative flags.
// Optional signed saturation on overflow is enabled by defining SERIAL_ADDSUB_SAT_EN (adds the i_sat port).
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADDSUB_SAT_EN
  input  logic             i_sat,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cf,
  output logic             o_ovf,
  output logic             o_zf,
  output logic             o_nf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0]    LAST_CNT = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;

  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT:0]   dsum_s;
  logic [WIDTH-1:0] acc_s;
  logic [WIDTH-1:0] final_s;
  logic             cf_s;
  logic             ovf_s;
  logic             clamp_s;

  assign accept_s = i_start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (cnt_r == LAST_CNT);

  // Operands shift right each RUN cycle, so the current digit is always the low DIGIT bits.
  assign a_dig_s = a_r[DIGIT-1:0];
  assign b_dig_s = b_r[DIGIT-1:0];
  assign dsum_s  = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};
  assign acc_s   = (acc_r >> DIGIT) | (WIDTH'(dsum_s[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Carry into the top bit is recovered from the sum bit and the two operand bits.
  assign cf_s  = dsum_s[DIGIT];
  assign ovf_s = cf_s ^ (dsum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1]);

`ifdef SERIAL_ADDSUB_SAT_EN
  logic sat_r;

  // Saturation request captured with the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_r <= 1'b0;
    end else if (accept_s) begin
      sat_r <= i_sat;
    end else begin
      sat_r <= sat_r;
    end
  end

  assign clamp_s = sat_r & ovf_s;
`else
  assign clamp_s = 1'b0;
`endif

  // Final result; on the last digit a_dig_s[DIGIT-1] is the sign of the latched first operand.
  always_comb begin
    final_s = acc_s;
    if (clamp_s) begin
      final_s = a_dig_s[DIGIT-1] ? MIN_NEG : MAX_POS;
    end else begin
      final_s = acc_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = i_start ? RUN : IDLE;
      RUN:     state_s = last_s ? DONE : RUN;
      DONE:    state_s = i_start ? RUN : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      a_r      <= ZERO;
      b_r      <= ZERO;
      acc_r    <= ZERO;
      carry_r  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= ZERO;
      o_cf     <= 1'b0;
      o_ovf    <= 1'b0;
      o_zf     <= 1'b0;
      o_nf     <= 1'b0;
    end else begin
      state_r <= state_s;
      o_busy  <= (state_s == RUN);
      o_done  <= (state_s == DONE);
      if (accept_s) begin
        a_r     <= i_a;
        b_r     <= i_b ^ {WIDTH{i_op}};
        carry_r <= i_op;
        cnt_r   <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        a_r     <= a_r >> DIGIT;
        b_r     <= b_r >> DIGIT;
        acc_r   <= acc_s;
        carry_r <= cf_s;
        cnt_r   <= cnt_r + CW'(1);
        if (last_s) begin
          o_result <= final_s;
          o_cf     <= cf_s;
          o_ovf    <= ovf_s;
          o_zf     <= (final_s == ZERO);
          o_nf     <= final_s[WIDTH-1];
        end else begin
          o_result <= o_result;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a DIGIT=4 and a DIGIT=16 instance, both 16 bits wide,
// checked against an arithmetic reference model with directed and $urandom stimulus.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        op_in = 1'b0;
  logic        sat_in = 1'b0;
  logic [15:0] a_in = 16'h0000;
  logic [15:0] b_in = 16'h0000;

  logic        busy0, done0, cf0, ovf0, zf0, nf0;
  logic        busy1, done1, cf1, ovf1, zf1, nf1;
  logic [15:0] res0, res1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .i_start(start0), .i_op(op_in), .i_a(a_in), .i_b(b_in),
`ifdef SERIAL_ADDSUB_SAT_EN
    .i_sat(sat_in),
`endif
    .o_busy(busy0), .o_done(done0), .o_result(res0),
    .o_cf(cf0), .o_ovf(ovf0), .o_zf(zf0), .o_nf(nf0)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .i_start(start1), .i_op(op_in), .i_a(a_in), .i_b(b_in),
`ifdef SERIAL_ADDSUB_SAT_EN
    .i_sat(sat_in),
`endif
    .o_busy(busy1), .o_done(done1), .o_result(res1),
    .o_cf(cf1), .o_ovf(ovf1), .o_zf(zf1), .o_nf(nf1)
  );

  // {busy, done, cf, ovf, zf, nf, result}
  function automatic logic [21:0] obs(input int u);
    if (u == 0) return {busy0, done0, cf0, ovf0, zf0, nf0, res0};
    else        return {busy1, done1, cf1, ovf1, zf1, nf1, res1};
  endfunction

  // Reference: {cf, ovf, zf, nf, result} from integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic op, input logic sat);
    int ua, ub, sa, sb, sr;
    logic [15:0] res;
    logic cf, ovf;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (op) begin
      res = a - b; cf = (ua >= ub); sr = sa - sb;
    end else begin
      res = a + b; cf = (ua + ub > 65535); sr = sa + sb;
    end
    ovf = (sr > 32767) || (sr < -32768);
    if (sat && ovf) res = a[15] ? 16'h8000 : 16'h7FFF;
    return {cf, ovf, (res == 16'h0000), res[15], res};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_start(input int u, input logic v);
    if (u == 0) start0 = v;
    else        start1 = v;
  endtask

  // One complete operation: latency, busy length, result/flags, one-cycle done, held outputs.
  task automatic do_op(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic op, input logic sat, input string tag);
    logic [19:0] exp;
    logic [21:0] o;
    int lat, busy_n, ndig;
    bit seen;
    ndig = (u == 0) ? 4 : 1;
    exp = model(a, b, op, sat & SAT_ON);
    @(negedge clk);
    a_in = a; b_in = b; op_in = op; sat_in = sat;
    set_start(u, 1'b1);
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        set_start(u, 1'b0);
        a_in = 16'($urandom); b_in = 16'($urandom); op_in = 1'($urandom); sat_in = 1'($urandom);
      end
      o = obs(u);
      if (o[21]) busy_n++;
      seen = o[20];
    end
    check({tag, " latency"}, lat, ndig + 1);
    check({tag, " busy cycles"}, busy_n, ndig);
    check({tag, " result/flags"}, o[19:0], exp);
    @(negedge clk);
    o = obs(u);
    check({tag, " done pulse+hold"}, o, {2'b00, exp});
  endtask

  initial begin
    logic [19:0] e1, e2;
    logic [21:0] o;
    int dones, t1, t2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dut4", obs(0), 22'h0);
    check("reset dut16", obs(1), 22'h0);
    rst = 1'b0;

    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, "add 1234+1111");
    check("add 1234+1111 value", res0, 16'h2345);
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, "sub 5-7");
    check("sub 5-7 value", {cf0, ovf0, nf0, res0}, {3'b001, 16'hFFFE});
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, "sub 8000-1");
    check("sub 8000-1 flags", {cf0, ovf0}, 2'b11);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, "add 7fff+1");
    check("add 7fff+1 flags", {cf0, ovf0}, 2'b01);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add ffff+1");
    check("add ffff+1 value", {cf0, ovf0, zf0, res0}, {3'b101, 16'h0000});
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add 7fff+1 wrap");
    check("wrap value", {nf0, res0}, {1'b1, 16'h8000});

    // start pulsed mid-RUN must be ignored
    e1 = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk); a_in = 16'h0F0F; b_in = 16'h0101; op_in = 1'b0; sat_in = 1'b0; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; op_in = 1'b1;
    @(negedge clk); start0 = 1'b0;
    dones = 0; o = 22'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) begin dones++; o = obs(0); end
    end
    check("midrun done count", dones, 1);
    check("midrun result", o[19:0], e1);

    // start held high across DONE: back-to-back
    e1 = model(16'h1357, 16'h2468, 1'b0, 1'b0);
    e2 = model(16'h9000, 16'h1001, 1'b1, 1'b0);
    @(negedge clk); a_in = 16'h1357; b_in = 16'h2468; op_in = 1'b0; start0 = 1'b1;
    @(negedge clk); a_in = 16'h9000; b_in = 16'h1001; op_in = 1'b1;
    dones = 0; t1 = 0; t2 = 0;
    for (int n = 2; n <= 16; n++) begin
      @(negedge clk);
      if (done0) begin
        dones++;
        if (dones == 1) begin t1 = n; check("b2b first", obs(0), {2'b01, e1}); end
        if (dones == 2) begin t2 = n; start0 = 1'b0; check("b2b second", obs(0), {2'b01, e2}); end
      end
    end
    start0 = 1'b0;
    check("b2b first latency", t1, 5);
    check("b2b spacing", t2 - t1, 5);
    check("b2b done count", dones, 2);

    // reset during the 2nd RUN cycle aborts the operation
    @(negedge clk); a_in = 16'h4321; b_in = 16'h1234; op_in = 1'b0; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort outputs", obs(0), 22'h0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) dones++;
    end
    check("abort no done", dones, 0);
    do_op(0, 16'h4321, 16'h1234, 1'b0, 1'b0, "after abort");

    for (int i = 0; i < 20; i++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand dut4");

    do_op(1, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, "dut16 a5a5+5a5b");
    check("dut16 value", {cf1, zf1, res1}, {2'b11, 16'h0000});
    for (int i = 0; i < 6; i++)
      do_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand dut16");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
